// File: rtl/traffic_pkg.sv
// Shared types and encodings for the pedestrian phase sequencer.
package traffic_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_VEH_GREEN  = 3'd0,
    ST_VEH_YELLOW = 3'd1,
    ST_ALLRED_A   = 3'd2,
    ST_PED_WALK   = 3'd3,
    ST_PED_FLASH  = 3'd4,
    ST_ALLRED_B   = 3'd5
  } state_e;

  // Vehicle light encodings
  localparam logic [1:0] VEH_RED    = 2'b00;
  localparam logic [1:0] VEH_YELLOW = 2'b01;
  localparam logic [1:0] VEH_GREEN  = 2'b10;

  // Pedestrian light encodings
  localparam logic [1:0] PED_DONT_WALK = 2'b00;
  localparam logic [1:0] PED_WALK      = 2'b01;
  localparam logic [1:0] PED_FLASH     = 2'b10;

  // Crossing indices into the flag / mask vectors
  localparam int unsigned TV      = 0;
  localparam int unsigned NN      = 1;
  localparam int unsigned NS      = 2;
  localparam int unsigned N_CROSS = 3;

  // Larger of two unsigned values, used for sizing the phase timer
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Pedestrian light for one crossing given the state it is about to show
  function automatic logic [1:0] ped_code(input state_e st, input logic served);
    logic [1:0] code;
    code = PED_DONT_WALK;
    if (served) begin
      if (st == ST_PED_WALK) begin
        code = PED_WALK;
      end else if (st == ST_PED_FLASH) begin
        code = PED_FLASH;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic resetN,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at the terminal count, otherwise increment
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pedestrian_phase_fsm.sv
// Vehicle/pedestrian phase sequencer serving three latched walk requests.
module pedestrian_phase_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 8,
  parameter int unsigned FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       walkFlagTv,
  input  logic       walkFlagNN,
  input  logic       walkFlagNS,
  output logic       resetTv,
  output logic       resetNN,
  output logic       resetNS,
  output logic [1:0] vehLight,
  output logic [1:0] pedLightTv,
  output logic [1:0] pedLightNN,
  output logic [1:0] pedLightNS
);

  localparam int unsigned MAX_DUR = max_u(max_u(max_u(MIN_GREEN, YELLOW_T), max_u(ALLRED_T, WALK_T)),
                                          FLASH_T);
  localparam int unsigned TMR_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [TMR_W-1:0] GREEN_LD  = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] YELLOW_LD = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] ALLRED_LD = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] WALK_LD   = TMR_W'(WALK_T - 1);
  localparam logic [TMR_W-1:0] FLASH_LD  = TMR_W'(FLASH_T - 1);

  logic                          tick;
  logic [N_CROSS-1:0]            flags;
  logic                          tmr_done;

  state_e                        state_q,  state_d;
  logic [TMR_W-1:0]              timer_q,  timer_d;
  logic [N_CROSS-1:0]            served_q, served_d;
  logic [N_CROSS-1:0]            clr_q,    clr_d;
  logic [1:0]                    veh_q,    veh_d;
  logic [N_CROSS-1:0][1:0]       ped_q,    ped_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .resetN (resetN),
    .tick   (tick)
  );

  assign flags    = {walkFlagNS, walkFlagNN, walkFlagTv};
  assign tmr_done = (timer_q == '0);

  // Next state, phase timer, served mask, clear pulses and next-cycle lights
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    served_d = served_q;
    clr_d    = '0;
    veh_d    = VEH_RED;
    ped_d    = '0;

    // Saturating countdown; a transition below overrides it with a fresh load
    if (tick && !tmr_done) begin
      timer_d = timer_q - TMR_W'(1);
    end

    case (state_q)
      ST_VEH_GREEN: begin
        // Green rests after expiry until some crossing is waiting
        if (tick && tmr_done && (|flags)) begin
          state_d  = ST_VEH_YELLOW;
          timer_d  = YELLOW_LD;
          served_d = flags;
        end
      end
      ST_VEH_YELLOW: begin
        if (tick && tmr_done) begin
          state_d = ST_ALLRED_A;
          timer_d = ALLRED_LD;
        end
      end
      ST_ALLRED_A: begin
        if (tick && tmr_done) begin
          state_d = ST_PED_WALK;
          timer_d = WALK_LD;
        end
      end
      ST_PED_WALK: begin
        if (tick && tmr_done) begin
          state_d = ST_PED_FLASH;
          timer_d = FLASH_LD;
        end
      end
      ST_PED_FLASH: begin
        // Only crossings served in this phase get their latch cleared
        if (tick && tmr_done) begin
          state_d  = ST_ALLRED_B;
          timer_d  = ALLRED_LD;
          clr_d    = served_q;
          served_d = '0;
        end
      end
      ST_ALLRED_B: begin
        if (tick && tmr_done) begin
          state_d = ST_VEH_GREEN;
          timer_d = GREEN_LD;
        end
      end
      default: begin
        // Unknown encoding: fall back to the all-red clearance
        state_d  = ST_ALLRED_B;
        timer_d  = ALLRED_LD;
        served_d = '0;
      end
    endcase

    // Lights follow the state being entered so they are registered with it
    if (state_d == ST_VEH_GREEN) begin
      veh_d = VEH_GREEN;
    end else if (state_d == ST_VEH_YELLOW) begin
      veh_d = VEH_YELLOW;
    end

    for (int i = 0; i < N_CROSS; i++) begin
      ped_d[i] = ped_code(state_d, served_d[i]);
    end
  end

  // State and output registers; reset holds all latch clears high
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_ALLRED_B;
      timer_q  <= ALLRED_LD;
      served_q <= '0;
      clr_q    <= '1;
      veh_q    <= VEH_RED;
      ped_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      served_q <= served_d;
      clr_q    <= clr_d;
      veh_q    <= veh_d;
      ped_q    <= ped_d;
    end
  end

  assign resetTv    = clr_q[TV];
  assign resetNN    = clr_q[NN];
  assign resetNS    = clr_q[NS];
  assign vehLight   = veh_q;
  assign pedLightTv = ped_q[TV];
  assign pedLightNN = ped_q[NN];
  assign pedLightNS = ped_q[NS];

endmodule

// File: tb/tb_pedestrian_phase_fsm.sv
// Directed bench for pedestrian_phase_fsm with a behavioural walk-request latch.
module tb_pedestrian_phase_fsm;

  logic       clk;
  logic       resetN;
  logic       walkFlagTv, walkFlagNN, walkFlagNS;
  logic       resetTv, resetNN, resetNS;
  logic [1:0] vehLight, pedLightTv, pedLightNN, pedLightNS;

  logic [2:0] press = 3'b000;
  logic [2:0] lat   = 3'b000;
  logic       mon_en = 1'b0;
  int         n_vec  = 0;
  int         n_bad  = 0;

  localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10;

  pedestrian_phase_fsm #(
    .TICK_DIV  (4),
    .MIN_GREEN (3),
    .YELLOW_T  (2),
    .ALLRED_T  (1),
    .WALK_T    (4),
    .FLASH_T   (2)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .walkFlagTv (walkFlagTv),
    .walkFlagNN (walkFlagNN),
    .walkFlagNS (walkFlagNS),
    .resetTv    (resetTv),
    .resetNN    (resetNN),
    .resetNS    (resetNS),
    .vehLight   (vehLight),
    .pedLightTv (pedLightTv),
    .pedLightNN (pedLightNN),
    .pedLightNS (pedLightNS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request latch model: clear has priority over a press
  always @(posedge clk) begin
    lat <= (lat | press) & ~{resetNS, resetNN, resetTv};
  end
  assign {walkFlagNS, walkFlagNN, walkFlagTv} = lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Safety: any pedestrian light other than DONT_WALK requires vehicle RED
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("safety",
               32'((vehLight != R) && ({pedLightNS, pedLightNN, pedLightTv} != 6'b0)),
               32'd0);
    end
  end

  // Advance n cycles, checking {veh, ped NS/NN/Tv, clear NS/NN/Tv} after each edge
  task automatic seg(input string tag, input int n, input logic [1:0] veh,
                     input logic [5:0] ped, input logic [2:0] clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag,
               32'({vehLight, pedLightNS, pedLightNN, pedLightTv, resetNS, resetNN, resetTv}),
               32'({veh, ped, clr}));
    end
  endtask

  initial begin
    resetN = 1'b0;

    // 1: reset held for 3 edges, then release; ALLRED_B runs out the tick
    mon_en = 1'b1;
    seg("rst_hold", 3, R, 6'b0, 3'b111);
    resetN = 1'b1;
    seg("rst_allred", 3, R, 6'b0, 3'b000);

    // 3: NN request at green cycle 2 -> full phase for NN
    seg("t3_green", 2, G, 6'b0, 3'b000);
    press = 3'b010;
    seg("t3_green", 1, G, 6'b0, 3'b000);
    press = 3'b000;
    seg("t3_green", 9, G, 6'b0, 3'b000);
    seg("t3_yellow", 8, Y, 6'b0, 3'b000);
    seg("t3_allred_a", 4, R, 6'b0, 3'b000);
    seg("t3_walk", 16, R, 6'b000100, 3'b000);
    seg("t3_flash", 8, R, 6'b001000, 3'b000);
    seg("t3_clear", 1, R, 6'b0, 3'b010);
    seg("t3_allred_b", 3, R, 6'b0, 3'b000);

    // 4: Tv and NS one cycle apart -> served together
    seg("t4_green", 4, G, 6'b0, 3'b000);
    press = 3'b001;
    seg("t4_green", 1, G, 6'b0, 3'b000);
    press = 3'b100;
    seg("t4_green", 1, G, 6'b0, 3'b000);
    press = 3'b000;
    seg("t4_green", 6, G, 6'b0, 3'b000);
    seg("t4_yellow", 8, Y, 6'b0, 3'b000);
    seg("t4_allred_a", 4, R, 6'b0, 3'b000);
    seg("t4_walk", 16, R, 6'b010001, 3'b000);
    seg("t4_flash", 8, R, 6'b100010, 3'b000);
    seg("t4_clear", 1, R, 6'b0, 3'b101);
    seg("t4_allred_b", 3, R, 6'b0, 3'b000);

    // 5: Tv served; NN pressed during walk waits a full minimum green
    seg("t5_green", 1, G, 6'b0, 3'b000);
    press = 3'b001;
    seg("t5_green", 1, G, 6'b0, 3'b000);
    press = 3'b000;
    seg("t5_green", 10, G, 6'b0, 3'b000);
    seg("t5_yellow", 8, Y, 6'b0, 3'b000);
    seg("t5_allred_a", 4, R, 6'b0, 3'b000);
    seg("t5_walk_tv", 3, R, 6'b000001, 3'b000);
    press = 3'b010;
    seg("t5_walk_tv", 1, R, 6'b000001, 3'b000);
    press = 3'b000;
    seg("t5_walk_tv", 12, R, 6'b000001, 3'b000);
    seg("t5_flash_tv", 8, R, 6'b000010, 3'b000);
    seg("t5_clear_tv", 1, R, 6'b0, 3'b001);
    seg("t5_allred_b", 3, R, 6'b0, 3'b000);
    seg("t5_green_nn", 12, G, 6'b0, 3'b000);
    seg("t5_yellow_nn", 8, Y, 6'b0, 3'b000);
    seg("t5_allred_nn", 4, R, 6'b0, 3'b000);
    seg("t5_walk_nn", 16, R, 6'b000100, 3'b000);
    seg("t5_flash_nn", 8, R, 6'b001000, 3'b000);
    seg("t5_clear_nn", 1, R, 6'b0, 3'b010);
    seg("t5_allred_b2", 3, R, 6'b0, 3'b000);

    // 2: no requests -> green rests
    seg("t2_rest", 200, G, 6'b0, 3'b000);

    // 6: request after expiry exits on the next tick; reset aborts mid walk
    press = 3'b001;
    seg("t6_green", 1, G, 6'b0, 3'b000);
    press = 3'b000;
    seg("t6_green", 3, G, 6'b0, 3'b000);
    seg("t6_yellow", 8, Y, 6'b0, 3'b000);
    seg("t6_allred_a", 4, R, 6'b0, 3'b000);
    seg("t6_walk", 6, R, 6'b000001, 3'b000);
    resetN = 1'b0;
    seg("t6_abort", 2, R, 6'b0, 3'b111);
    resetN = 1'b1;
    seg("t6_allred_b", 3, R, 6'b0, 3'b000);
    seg("t6_green_idle", 20, G, 6'b0, 3'b000);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
